// File: rtl/axi_rd_arbiter.sv
// Read-channel arbiter: shares one AXI AR/R path between the fetch and load ports.
// One single-beat read outstanding at a time; round-robin on contention.
module axi_rd_arbiter #(
    parameter int          ADDR_WIDTH = 32,
    parameter int          DATA_WIDTH = 32,
    parameter logic [3:0]  ID_INST    = 4'd0,
    parameter logic [3:0]  ID_DATA    = 4'd1
) (
    input  logic                  aclk,
    input  logic                  aresetn,

    input  logic                  inst_req,
    input  logic [ADDR_WIDTH-1:0] inst_addr,
    input  logic [1:0]            inst_size,
    output logic                  inst_addr_ok,
    output logic                  inst_data_ok,
    output logic [DATA_WIDTH-1:0] inst_rdata,

    input  logic                  data_req,
    input  logic [ADDR_WIDTH-1:0] data_addr,
    input  logic [1:0]            data_size,
    output logic                  data_addr_ok,
    output logic                  data_data_ok,
    output logic [DATA_WIDTH-1:0] data_rdata,

    output logic [3:0]            arid,
    output logic [ADDR_WIDTH-1:0] araddr,
    output logic [2:0]            arsize,
    output logic                  arvalid,
    input  logic                  arready,

    input  logic [3:0]            rid,
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic                  rvalid,
    output logic                  rready
);

    // state | meaning
    // IDLE  | no read outstanding; arbitrate and grant a requester
    // ADDR  | AR presented from latches until arready
    // DATA  | waiting for an R beat carrying the latched id
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic                  last_grant_q;   // 0: fetch won last, 1: load won last
    logic                  sel_q;          // owner of the outstanding read, 1 = load
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [1:0]            size_q;
    logic [3:0]            id_q;
    logic                  grant_inst;
    logic                  grant_data;
    logic                  grant_any;
    logic                  beat_hit;

    always_comb begin
        grant_inst = 1'b0;
        grant_data = 1'b0;
        state_d    = state_q;
        case (state_q)
            IDLE: begin
                if (inst_req && data_req) begin
                    grant_data = !last_grant_q;
                    grant_inst = last_grant_q;
                end else begin
                    grant_inst = inst_req;
                    grant_data = data_req;
                end
                if (grant_inst || grant_data) begin
                    state_d = ADDR;
                end
            end
            ADDR: begin
                if (arready) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (beat_hit) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign grant_any = grant_inst || grant_data;
    // Beats tagged with another id are accepted (rready high) and discarded.
    assign beat_hit  = (state_q == DATA) && rvalid && (rid == id_q);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            last_grant_q <= 1'b0;
            sel_q        <= 1'b0;
            addr_q       <= '0;
            size_q       <= '0;
            id_q         <= '0;
            inst_data_ok <= 1'b0;
            data_data_ok <= 1'b0;
            inst_rdata   <= '0;
            data_rdata   <= '0;
        end else begin
            inst_data_ok <= beat_hit && !sel_q;
            data_data_ok <= beat_hit && sel_q;
            if (beat_hit && !sel_q) begin
                inst_rdata <= rdata;
            end
            if (beat_hit && sel_q) begin
                data_rdata <= rdata;
            end
            if (grant_any) begin
                sel_q        <= grant_data;
                last_grant_q <= grant_data;
                addr_q       <= grant_data ? data_addr : inst_addr;
                size_q       <= grant_data ? data_size : inst_size;
                id_q         <= grant_data ? ID_DATA : ID_INST;
            end
        end
    end

    // Grants are gated by reset so every output reads 0 while aresetn is low.
    assign inst_addr_ok = grant_inst && aresetn;
    assign data_addr_ok = grant_data && aresetn;

    assign arvalid = (state_q == ADDR);
    assign rready  = (state_q == DATA);
    assign araddr  = addr_q;
    assign arsize  = {1'b0, size_q};
    assign arid    = id_q;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter: fetch, contention, AR backpressure,
// foreign rid and reset mid-read, with hand-computed expectations.
module tb_axi_rd_arbiter;

    logic        aclk;
    logic        aresetn;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic [1:0]  inst_size;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req;
    logic [31:0] data_addr;
    logic [1:0]  data_size;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [2:0]  arsize;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic        rvalid;
    logic        rready;

    int checks = 0;
    int errors = 0;

    axi_rd_arbiter dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_size    (inst_size),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .data_req     (data_req),
        .data_addr    (data_addr),
        .data_size    (data_size),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .arid         (arid),
        .araddr       (araddr),
        .arsize       (arsize),
        .arvalid      (arvalid),
        .arready      (arready),
        .rid          (rid),
        .rdata        (rdata),
        .rvalid       (rvalid),
        .rready       (rready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge; inputs change here.
    task automatic nxt();
        @(posedge aclk);
        #1;
    endtask

    initial begin
        aresetn   = 1'b0;
        inst_req  = 1'b0;
        inst_addr = '0;
        inst_size = '0;
        data_req  = 1'b0;
        data_addr = '0;
        data_size = '0;
        arready   = 1'b0;
        rid       = '0;
        rdata     = '0;
        rvalid    = 1'b0;

        // Reset held 3 cycles
        nxt(); nxt(); nxt();
        #2;
        check("rst_inst_addr_ok", inst_addr_ok, 0);
        check("rst_data_addr_ok", data_addr_ok, 0);
        check("rst_inst_data_ok", inst_data_ok, 0);
        check("rst_data_data_ok", data_data_ok, 0);
        check("rst_inst_rdata", inst_rdata, 0);
        check("rst_data_rdata", data_rdata, 0);
        check("rst_arvalid", arvalid, 0);
        check("rst_araddr", araddr, 0);
        check("rst_arid", arid, 0);
        check("rst_arsize", arsize, 0);
        check("rst_rready", rready, 0);
        nxt();
        aresetn = 1'b1;
        nxt(); #2;
        check("idle_arvalid_0", arvalid, 0);
        nxt(); #2;
        check("idle_arvalid_1", arvalid, 0);

        // Fetch, zero-wait slave
        nxt();
        inst_req  = 1'b1;
        inst_addr = 32'hBFC0_0000;
        inst_size = 2'd2;
        arready   = 1'b1;
        #2;
        check("fetch_addr_ok_T", inst_addr_ok, 1);
        check("fetch_data_addr_ok_T", data_addr_ok, 0);
        check("fetch_arvalid_T", arvalid, 0);
        nxt();
        inst_req = 1'b0;
        #2;
        check("fetch_arvalid_T1", arvalid, 1);
        check("fetch_araddr", araddr, 32'hBFC0_0000);
        check("fetch_arsize", arsize, 2);
        check("fetch_arid", arid, 0);
        check("fetch_addr_ok_T1", inst_addr_ok, 0);
        nxt();
        rvalid = 1'b1;
        rid    = 4'd0;
        rdata  = 32'h3C1D_8000;
        #2;
        check("fetch_rready_T2", rready, 1);
        check("fetch_arvalid_T2", arvalid, 0);
        check("fetch_data_ok_T2", inst_data_ok, 0);
        nxt();
        rvalid = 1'b0;
        #2;
        check("fetch_data_ok_T3", inst_data_ok, 1);
        check("fetch_rdata", inst_rdata, 32'h3C1D_8000);
        check("fetch_load_data_ok", data_data_ok, 0);
        check("fetch_rready_T3", rready, 0);
        nxt(); #2;
        check("fetch_data_ok_pulse", inst_data_ok, 0);
        check("fetch_rdata_hold", inst_rdata, 32'h3C1D_8000);

        // Fresh reset, then contention: load first
        aresetn = 1'b0;
        #2;
        check("rst2_inst_rdata", inst_rdata, 0);
        nxt();
        aresetn   = 1'b1;
        nxt();
        inst_req  = 1'b1;
        inst_addr = 32'h0000_1000;
        inst_size = 2'd2;
        data_req  = 1'b1;
        data_addr = 32'h0000_2000;
        data_size = 2'd1;
        #2;
        check("cont1_data_addr_ok", data_addr_ok, 1);
        check("cont1_inst_addr_ok", inst_addr_ok, 0);
        nxt();
        data_req = 1'b0;
        #2;
        check("cont1_arid", arid, 1);
        check("cont1_araddr", araddr, 32'h0000_2000);
        check("cont1_arsize", arsize, 1);
        check("cont1_inst_wait_addr", inst_addr_ok, 0);
        nxt();
        rvalid = 1'b1;
        rid    = 4'd1;
        rdata  = 32'hAAAA_5555;
        #2;
        check("cont1_inst_wait_data", inst_addr_ok, 0);
        nxt();
        rvalid = 1'b0;
        #2;
        check("cont1_data_data_ok", data_data_ok, 1);
        check("cont1_data_rdata", data_rdata, 32'hAAAA_5555);
        check("cont1_inst_data_ok", inst_data_ok, 0);
        check("cont2_inst_addr_ok", inst_addr_ok, 1);
        nxt();
        inst_req = 1'b0;
        #2;
        check("cont2_arid", arid, 0);
        check("cont2_araddr", araddr, 32'h0000_1000);
        check("cont2_arvalid", arvalid, 1);
        nxt();
        rvalid = 1'b1;
        rid    = 4'd0;
        rdata  = 32'h1234_5678;
        nxt();
        rvalid    = 1'b0;
        inst_req  = 1'b1;
        inst_addr = 32'h0000_1004;
        data_req  = 1'b1;
        data_addr = 32'h0000_2004;
        #2;
        check("cont2_inst_data_ok", inst_data_ok, 1);
        check("cont2_inst_rdata", inst_rdata, 32'h1234_5678);
        check("cont3_data_addr_ok", data_addr_ok, 1);
        check("cont3_inst_addr_ok", inst_addr_ok, 0);
        nxt();
        data_req = 1'b0;
        #2;
        check("cont3_arid", arid, 1);
        check("cont3_araddr", araddr, 32'h0000_2004);
        nxt();
        rvalid = 1'b1;
        rid    = 4'd1;
        rdata  = 32'h0000_BEEF;
        nxt();
        rvalid    = 1'b0;
        data_req  = 1'b1;
        data_addr = 32'h0000_2008;
        data_size = 2'd2;
        #2;
        check("cont3_data_data_ok", data_data_ok, 1);
        check("cont3_data_rdata", data_rdata, 32'h0000_BEEF);
        check("cont4_inst_addr_ok", inst_addr_ok, 1);
        check("cont4_data_addr_ok", data_addr_ok, 0);
        nxt();
        inst_req = 1'b0;
        #2;
        check("cont4_arid", arid, 0);
        check("cont4_araddr", araddr, 32'h0000_1004);
        nxt();
        rvalid = 1'b1;
        rid    = 4'd0;
        rdata  = 32'h1111_2222;
        nxt();
        rvalid = 1'b0;
        #2;
        check("cont4_inst_data_ok", inst_data_ok, 1);
        check("cont4_inst_rdata", inst_rdata, 32'h1111_2222);
        check("cont5_data_addr_ok", data_addr_ok, 1);

        // AR backpressure with a fetch waiting
        nxt();
        data_req  = 1'b0;
        arready   = 1'b0;
        inst_req  = 1'b1;
        inst_addr = 32'h0000_1008;
        for (int i = 0; i < 5; i++) begin
            #2;
            check("bp_arvalid", arvalid, 1);
            check("bp_araddr", araddr, 32'h0000_2008);
            check("bp_arid", arid, 1);
            check("bp_inst_addr_ok", inst_addr_ok, 0);
            nxt();
        end
        arready = 1'b1;
        #2;
        check("bp_arvalid_release", arvalid, 1);
        check("bp_araddr_release", araddr, 32'h0000_2008);
        nxt();
        #2;
        check("bp_data_arvalid", arvalid, 0);
        check("bp_data_rready", rready, 1);
        check("bp_data_inst_addr_ok", inst_addr_ok, 0);

        // Foreign rid beat is dropped
        rvalid = 1'b1;
        rid    = 4'd5;
        rdata  = 32'hDEAD_DEAD;
        nxt();
        rvalid = 1'b0;
        #2;
        check("frid_data_data_ok", data_data_ok, 0);
        check("frid_inst_data_ok", inst_data_ok, 0);
        check("frid_rready", rready, 1);
        check("frid_data_rdata_hold", data_rdata, 32'h0000_BEEF);
        check("frid_inst_addr_ok", inst_addr_ok, 0);
        rvalid = 1'b1;
        rid    = 4'd1;
        rdata  = 32'hCAFE_F00D;
        nxt();
        rvalid = 1'b0;
        #2;
        check("frid_match_data_ok", data_data_ok, 1);
        check("frid_match_rdata", data_rdata, 32'hCAFE_F00D);
        check("frid_inst_granted", inst_addr_ok, 1);

        // Reset while in DATA
        nxt();
        inst_req = 1'b0;
        #2;
        check("rstd_arvalid_pre", arvalid, 1);
        nxt();
        #2;
        check("rstd_rready_pre", rready, 1);
        rvalid  = 1'b1;
        rid     = 4'd0;
        rdata   = 32'h0000_0099;
        aresetn = 1'b0;
        #1;
        check("rstd_arvalid", arvalid, 0);
        check("rstd_rready", rready, 0);
        check("rstd_inst_data_ok", inst_data_ok, 0);
        nxt();
        #2;
        check("rstd_inst_data_ok_edge", inst_data_ok, 0);
        check("rstd_inst_rdata", inst_rdata, 0);
        rvalid  = 1'b0;
        aresetn = 1'b1;
        nxt();
        data_req  = 1'b1;
        data_addr = 32'h0000_3000;
        data_size = 2'd0;
        #2;
        check("post_rst_data_addr_ok", data_addr_ok, 1);
        nxt();
        data_req = 1'b0;
        #2;
        check("post_rst_arvalid", arvalid, 1);
        check("post_rst_arid", arid, 1);
        check("post_rst_araddr", araddr, 32'h0000_3000);
        check("post_rst_arsize", arsize, 0);
        nxt();
        rvalid = 1'b1;
        rid    = 4'd1;
        rdata  = 32'h0000_0055;
        #2;
        check("post_rst_rready", rready, 1);
        nxt();
        rvalid = 1'b0;
        #2;
        check("post_rst_data_data_ok", data_data_ok, 1);
        check("post_rst_data_rdata", data_rdata, 32'h0000_0055);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
